// File: rtl/sha_pkg.sv
// Shared constants, state type and padding helper for the SHA-256 message padder.
package sha_pkg;

  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam logic [6:0] LAST_SINGLE = 7'd55;
  localparam logic [6:0] BLK_BYTES   = 7'd64;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    XTRA = 2'd2
  } pad_state_t;

  // c is the count of message bytes in the block. The marker lands at byte c,
  // and a shift of 512 (c == 64) leaves no marker. The length goes in only
  // when it fits behind the marker.
  function automatic logic [511:0] pad_block(input logic [511:0] blk,
                                             input logic [6:0]   c,
                                             input logic [63:0]  len);
    logic [511:0] r;
    r = blk | ({PAD_BYTE, 504'b0} >> {c, 3'b000});
    if (c <= LAST_SINGLE) r[63:0] = len;
    return r;
  endfunction

endpackage

// File: rtl/sha_msg_padder.sv
// Byte-stream to padded 512-bit SHA-256 block converter with valid/ready block
// handshake and first/last block flags.
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int unsigned MSG_SIZ = 512,
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned LEN_W   = 64
) (
  input  logic               usr_clk,
  input  logic               usr_reset,
  input  logic [BYTE_W-1:0]  i_data,
  input  logic               i_data_valid,
  input  logic               i_data_last,
  output logic               o_data_ready,
  output logic [MSG_SIZ-1:0] o_blk,
  output logic               o_blk_valid,
  input  logic               i_blk_ready,
  output logic               o_blk_first,
  output logic               o_blk_last
);

  pad_state_t         state_q, state_d;
  logic [MSG_SIZ-1:0] buf_q, buf_d;
  logic [5:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               first_q, first_d;
  logic               extra_q, extra_d;
  logic               mark_q, mark_d;
  logic               last_q, last_d;
  logic               bfirst_q, bfirst_d;

  logic [MSG_SIZ-1:0] wbuf;
  logic [6:0]         c;

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state_q  <= FILL;
      buf_q    <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      extra_q  <= 1'b0;
      mark_q   <= 1'b0;
      last_q   <= 1'b0;
      bfirst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      first_q  <= first_d;
      extra_q  <= extra_d;
      mark_q   <= mark_d;
      last_q   <= last_d;
      bfirst_q <= bfirst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    len_d    = len_q;
    first_d  = first_q;
    extra_d  = extra_q;
    mark_d   = mark_q;
    last_d   = last_q;
    bfirst_d = bfirst_q;
    // Buffer bytes beyond idx are always zero, so OR-ing the byte in is enough.
    wbuf     = buf_q | ({i_data, {(MSG_SIZ-BYTE_W){1'b0}}} >> {idx_q, 3'b000});
    c        = {1'b0, idx_q} + 7'd1;

    o_data_ready = (state_q == FILL);
    o_blk_valid  = (state_q != FILL);

    case (state_q)
      FILL: begin
        if (i_data_valid) begin
          len_d    = len_q + LEN_W'(8);
          idx_d    = idx_q + 6'd1;
          bfirst_d = first_q;
          if (i_data_last) begin
            buf_d   = pad_block(wbuf, c, len_d);
            state_d = SEND;
            if (c <= LAST_SINGLE) begin
              last_d = 1'b1;
            end else begin
              last_d  = 1'b0;
              extra_d = 1'b1;
              mark_d  = (c == BLK_BYTES);
            end
          end else begin
            buf_d = wbuf;
            if (idx_q == 6'd63) begin
              state_d = SEND;
              last_d  = 1'b0;
            end
          end
        end
      end
      SEND: begin
        if (i_blk_ready) begin
          if (extra_q) begin
            buf_d    = {(mark_q ? PAD_BYTE : 8'h00),
                        {(MSG_SIZ-BYTE_W-LEN_W){1'b0}}, len_q};
            extra_d  = 1'b0;
            bfirst_d = 1'b0;
            last_d   = 1'b1;
            state_d  = XTRA;
          end else if (last_q) begin
            buf_d    = '0;
            idx_d    = '0;
            len_d    = '0;
            first_d  = 1'b1;
            last_d   = 1'b0;
            bfirst_d = 1'b0;
            state_d  = FILL;
          end else begin
            buf_d    = '0;
            idx_d    = '0;
            first_d  = 1'b0;
            bfirst_d = 1'b0;
            state_d  = FILL;
          end
        end
      end
      XTRA: begin
        if (i_blk_ready) begin
          buf_d    = '0;
          idx_d    = '0;
          len_d    = '0;
          first_d  = 1'b1;
          last_d   = 1'b0;
          bfirst_d = 1'b0;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign o_blk       = buf_q;
  assign o_blk_first = bfirst_q;
  assign o_blk_last  = last_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: a padded-message model feeds an expected
// block queue that one compare process checks on every block transfer.
module tb_sha_msg_padder;

  logic         usr_clk = 1'b0;
  logic         usr_reset;
  logic [7:0]   i_data;
  logic         i_data_valid;
  logic         i_data_last;
  logic         o_data_ready;
  logic [511:0] o_blk;
  logic         o_blk_valid;
  logic         i_blk_ready;
  logic         o_blk_first;
  logic         o_blk_last;

  sha_msg_padder #(.MSG_SIZ(512), .BYTE_W(8), .LEN_W(64)) dut (
    .usr_clk      (usr_clk),
    .usr_reset    (usr_reset),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_data_last  (i_data_last),
    .o_data_ready (o_data_ready),
    .o_blk        (o_blk),
    .o_blk_valid  (o_blk_valid),
    .i_blk_ready  (i_blk_ready),
    .o_blk_first  (o_blk_first),
    .o_blk_last   (o_blk_last)
  );

  always #5 usr_clk = ~usr_clk;

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'b0, 64'h18};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Model: message, 0x80, zeros up to 56 mod 64, 64-bit big-endian bit count.
  task automatic build_expected();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int unsigned  nblk;
    exp_t         e;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int unsigned b = 0; b < nblk; b++) begin
      blk = '0;
      for (int unsigned j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      e.blk   = blk;
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input logic last);
    int unsigned n = 0;
    bit done = 0;
    i_data = b; i_data_valid = 1'b1; i_data_last = last;
    while (!done) begin
      @(negedge usr_clk);
      if (o_data_ready) done = 1;
      else begin
        n++;
        if (n > 300) begin
          n_checks++;
          $display("FAIL byte_accept_timeout: o_data_ready got 0 expected 1");
          done = 1;
        end
      end
    end
    @(posedge usr_clk); #1;
    i_data_valid = 1'b0; i_data_last = 1'b0;
  endtask

  task automatic send_msg();
    for (int unsigned i = 0; i < msg.size(); i++) put_byte(msg[i], i == msg.size() - 1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge usr_clk); n++;
    end
    #1;
    chk("drain_all_blocks", 512'(exp_q.size()), 512'd0);
  endtask

  // Compare process: every accepted block must match the head of the model queue.
  always @(negedge usr_clk) begin
    exp_t e;
    if (!usr_reset && o_blk_valid && i_blk_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_block: got %h expected none", o_blk);
      end else begin
        e = exp_q.pop_front();
        chk("blk_data",  o_blk, e.blk);
        chk("blk_first", 512'(o_blk_first), 512'(e.first));
        chk("blk_last",  512'(o_blk_last),  512'(e.last));
      end
    end
  end

  initial begin
    logic [511:0] cap_blk;
    logic         cap_first, cap_last;

    usr_reset = 1'b1; i_data = '0; i_data_valid = 1'b0; i_data_last = 1'b0; i_blk_ready = 1'b1;
    repeat (2) @(posedge usr_clk);
    #1 usr_reset = 1'b0;
    chk("reset_data_ready", 512'(o_data_ready), 512'd1);
    chk("reset_blk_valid",  512'(o_blk_valid),  512'd0);
    chk("reset_blk",        o_blk,              512'd0);
    chk("reset_first_last", 512'({o_blk_first, o_blk_last}), 512'd0);

    // "abc"
    msg = {8'h61, 8'h62, 8'h63};
    build_expected();
    chk("model_abc_blk", exp_q[0].blk, ABC_BLK);
    send_msg();
    chk("abc_valid_latency", 512'(o_blk_valid), 512'd1);
    drain();

    // 55 bytes: marker and length share one block
    msg = {};
    for (int i = 0; i < 55; i++) msg.push_back(8'h61);
    build_expected();
    chk("model_55_count",  512'(exp_q.size()), 512'd1);
    chk("model_55_len",    512'(exp_q[0].blk[63:0]), 512'h1B8);
    chk("model_55_marker", 512'(exp_q[0].blk[71:64]), 512'h80);
    send_msg();
    drain();

    // 56 bytes: marker in block 1, length alone in block 2
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'h61);
    build_expected();
    chk("model_56_count",  512'(exp_q.size()), 512'd2);
    chk("model_56_blk2",   exp_q[1].blk, {448'b0, 64'h1C0});
    send_msg();
    drain();

    // 64 zero bytes: marker deferred to the extra block
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'h00);
    build_expected();
    chk("model_64_blk1",   exp_q[0].blk, 512'd0);
    chk("model_64_blk2",   exp_q[1].blk, {8'h80, 440'b0, 64'h200});
    send_msg();
    drain();

    // Stall: core not ready for 5 cycles while a byte is offered
    i_blk_ready = 1'b0;
    msg = {8'h61, 8'h62, 8'h63};
    build_expected();
    send_msg();
    cap_blk = o_blk; cap_first = o_blk_first; cap_last = o_blk_last;
    i_data = 8'hEE; i_data_valid = 1'b1; i_data_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge usr_clk);
      chk("stall_valid",      512'(o_blk_valid),  512'd1);
      chk("stall_blk",        o_blk,              cap_blk);
      chk("stall_first_last", 512'({o_blk_first, o_blk_last}), 512'({cap_first, cap_last}));
      chk("stall_data_ready", 512'(o_data_ready), 512'd0);
    end
    chk("stall_blk_abc", cap_blk, ABC_BLK);
    @(posedge usr_clk); #1;
    i_data_valid = 1'b0; i_data_last = 1'b0; i_blk_ready = 1'b1;
    @(posedge usr_clk); #1;
    chk("release_data_ready", 512'(o_data_ready), 512'd1);
    drain();

    // Reset mid-message discards the partial block
    msg = {};
    for (int i = 0; i < 10; i++) put_byte(8'h11, 1'b0);
    usr_reset = 1'b1;
    @(posedge usr_clk); #1 usr_reset = 1'b0;
    chk("midreset_blk_valid",  512'(o_blk_valid),  512'd0);
    chk("midreset_data_ready", 512'(o_data_ready), 512'd1);
    msg = {8'h61, 8'h62, 8'h63};
    build_expected();
    chk("model_abc_again", exp_q[0].blk, ABC_BLK);
    send_msg();
    chk("abc_again_len", 512'(o_blk[63:0]), 512'h18);
    drain();

    repeat (3) @(posedge usr_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
